// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue : circular instruction FIFO between fetch and decode.
//
// Buffers {pc, inst, bht_idx, pred_taken, pred_target} from fetch and presents
// the oldest entry to decode. A flush (branch mispredict) empties the queue in
// one cycle. The array is read combinationally at head_ptr, so an entry pushed
// into an empty queue shows up at iq_* one cycle later (no fetch->decode bypass).
//
// Parameters
//   DEPTH      number of entries (power of 2, >= 2)
//   BHT_IDX_W  width of the stored BHT index
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   flush                          drop every entry (next state empty)
//   fetch_valid / fetch_ready      push handshake
//   fetch_pc, fetch_inst, fetch_bht_idx, fetch_pred_taken, fetch_pred_target
//                                  pushed payload
//   iq_valid / iq_ready            pop handshake
//   iq_pc, iq_inst, iq_bht_idx, iq_pred_taken, iq_pred_target
//                                  head payload (meaningful while iq_valid)
//   iq_count                       occupancy, 0..DEPTH
//
// Configuration macro
//   INST_QUEUE_FULL_PUSH_EN  when defined, a full queue still accepts a push in
//                            a cycle where decode pops the head.
// -----------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH     = 4,
    parameter int BHT_IDX_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [31:0]                fetch_pc,
    input  logic [31:0]                fetch_inst,
    input  logic [BHT_IDX_W-1:0]       fetch_bht_idx,
    input  logic                       fetch_pred_taken,
    input  logic [31:0]                fetch_pred_target,
    output logic                       iq_valid,
    input  logic                       iq_ready,
    output logic [31:0]                iq_pc,
    output logic [31:0]                iq_inst,
    output logic [BHT_IDX_W-1:0]       iq_bht_idx,
    output logic                       iq_pred_taken,
    output logic [31:0]                iq_pred_target,
    output logic [$clog2(DEPTH):0]     iq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic [BHT_IDX_W-1:0] bht_idx;
        logic                 pred_taken;
        logic [31:0]          pred_target;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;
    entry_t           head_entry;

    assign full     = (count == CNT_W'(DEPTH));
    assign iq_valid = (count != '0);
    assign iq_count = count;

`ifdef INST_QUEUE_FULL_PUSH_EN
    // When full, tail_ptr == head_ptr; the head is read before the edge, so
    // overwriting that slot while it is popped is safe.
    assign fetch_ready = !full || iq_ready;
`else
    assign fetch_ready = !full;
`endif

    assign push = fetch_valid && fetch_ready;
    assign pop  = iq_valid && iq_ready;

    assign head_entry     = mem[head_ptr];
    assign iq_pc          = head_entry.pc;
    assign iq_inst        = head_entry.inst;
    assign iq_bht_idx     = head_entry.bht_idx;
    assign iq_pred_taken  = head_entry.pred_taken;
    assign iq_pred_target = head_entry.pred_target;

    // Control state: flush overrides any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push)
                tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop)
                head_ptr <= head_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage is not reset; stale slots are never visible while count
    // excludes them.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[tail_ptr] <= '{pc:          fetch_pc,
                               inst:        fetch_inst,
                               bht_idx:     fetch_bht_idx,
                               pred_taken:  fetch_pred_taken,
                               pred_target: fetch_pred_target};
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue : directed self-checking bench for inst_queue (DEPTH=4).
// -----------------------------------------------------------------------------
module tb_inst_queue;

    localparam int DEPTH     = 4;
    localparam int BHT_IDX_W = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic                 fetch_valid;
    logic                 fetch_ready;
    logic [31:0]          fetch_pc;
    logic [31:0]          fetch_inst;
    logic [BHT_IDX_W-1:0] fetch_bht_idx;
    logic                 fetch_pred_taken;
    logic [31:0]          fetch_pred_target;
    logic                 iq_valid;
    logic                 iq_ready;
    logic [31:0]          iq_pc;
    logic [31:0]          iq_inst;
    logic [BHT_IDX_W-1:0] iq_bht_idx;
    logic                 iq_pred_taken;
    logic [31:0]          iq_pred_target;
    logic [2:0]           iq_count;

    int n_chk  = 0;
    int n_pass = 0;

    inst_queue #(.DEPTH(DEPTH), .BHT_IDX_W(BHT_IDX_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_pc         (fetch_pc),
        .fetch_inst       (fetch_inst),
        .fetch_bht_idx    (fetch_bht_idx),
        .fetch_pred_taken (fetch_pred_taken),
        .fetch_pred_target(fetch_pred_target),
        .iq_valid         (iq_valid),
        .iq_ready         (iq_ready),
        .iq_pc            (iq_pc),
        .iq_inst          (iq_inst),
        .iq_bht_idx       (iq_bht_idx),
        .iq_pred_taken    (iq_pred_taken),
        .iq_pred_target   (iq_pred_target),
        .iq_count         (iq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input int i);
        fetch_pc          = pc;
        fetch_inst        = 32'h0000_0013 + 32'(i);
        fetch_bht_idx     = BHT_IDX_W'(i);
        fetch_pred_taken  = 1'(i & 1);
        fetch_pred_target = 32'h0000_5000 + 32'(i);
    endtask

    logic [31:0] exp_pc [4];

    initial begin
        rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; iq_ready = 1'b0;
        drive(32'h0, 0);
        #3;
        chk("rst_valid", 64'(iq_valid), 64'd0);
        chk("rst_count", 64'(iq_count), 64'd0);
        chk("rst_fready", 64'(fetch_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1'b1;
            drive(32'h1000 + 32'(4 * i), i);
            tick();
        end
        fetch_valid = 1'b0;
        chk("full_count", 64'(iq_count), 64'd4);
        chk("full_fready", 64'(fetch_ready), 64'd0);
        chk("full_head", 64'(iq_pc), 64'h1000);

        // Decode pops while fetch offers 0x3000 at the full queue.
        iq_ready    = 1'b1;
        fetch_valid = 1'b1;
        drive(32'h3000, 7);
`ifdef INST_QUEUE_FULL_PUSH_EN
        #1;
        chk("fpe_fready", 64'(fetch_ready), 64'd1);
        chk("fpe_head", 64'(iq_pc), 64'h1000);
        tick();
        fetch_valid = 1'b0;
        chk("fpe_count", 64'(iq_count), 64'd4);
        exp_pc[0] = 32'h1004; exp_pc[1] = 32'h1008;
        exp_pc[2] = 32'h100C; exp_pc[3] = 32'h3000;
`else
        #1;
        chk("stall_fready", 64'(fetch_ready), 64'd0);
        fetch_valid = 1'b0;
        exp_pc[0] = 32'h1000; exp_pc[1] = 32'h1004;
        exp_pc[2] = 32'h1008; exp_pc[3] = 32'h100C;
`endif
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_valid%0d", k), 64'(iq_valid), 64'd1);
            chk($sformatf("drain_pc%0d", k), 64'(iq_pc), 64'(exp_pc[k]));
            tick();
            if (k == 0)
                chk("drain_fready", 64'(fetch_ready), 64'd1);
        end
        chk("drain_empty", 64'(iq_valid), 64'd0);
        chk("drain_count", 64'(iq_count), 64'd0);
        iq_ready = 1'b0;

        // Streaming: one entry in flight, push and pop every cycle.
        fetch_valid = 1'b1;
        drive(32'h4000, 0);
        chk("no_bypass", 64'(iq_valid), 64'd0);
        tick();
        iq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fetch_valid = (i < 9);
            drive(32'h4000 + 32'(4 * (i + 1)), i + 1);
            #1;
            chk($sformatf("s_pc%0d", i), 64'(iq_pc), 64'(32'h4000 + 32'(4 * i)));
            chk($sformatf("s_inst%0d", i), 64'(iq_inst), 64'(32'h13 + 32'(i)));
            chk($sformatf("s_tk%0d", i), 64'(iq_pred_taken), 64'(i & 1));
            chk($sformatf("s_bht%0d", i), 64'(iq_bht_idx), 64'(i));
            chk($sformatf("s_cnt%0d", i), 64'(iq_count), 64'd1);
            tick();
        end
        fetch_valid = 1'b0;
        iq_ready    = 1'b0;
        chk("s_end_count", 64'(iq_count), 64'd0);

        // Flush with a simultaneous fetch offer.
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1'b1;
            drive(32'h6000 + 32'(4 * i), i);
            tick();
        end
        fetch_valid = 1'b0;
        chk("fl_pre_count", 64'(iq_count), 64'd3);
        flush = 1'b1;
        fetch_valid = 1'b1;
        drive(32'h2000, 5);
        #1;
        chk("fl_fready", 64'(fetch_ready), 64'd1);
        chk("fl_valid_in", 64'(iq_valid), 64'd1);
        tick();
        flush = 1'b0;
        fetch_valid = 1'b0;
        chk("fl_valid", 64'(iq_valid), 64'd0);
        chk("fl_count", 64'(iq_count), 64'd0);
        fetch_valid = 1'b1;
        drive(32'h7000, 1);
        tick();
        fetch_valid = 1'b0;
        chk("fl_after_pc", 64'(iq_pc), 64'h7000);
        chk("fl_after_cnt", 64'(iq_count), 64'd1);
        iq_ready = 1'b1;
        tick();
        iq_ready = 1'b0;
        chk("fl_after_empty", 64'(iq_valid), 64'd0);

        // Asynchronous reset mid-cycle with two entries queued.
        for (int i = 0; i < 2; i++) begin
            fetch_valid = 1'b1;
            drive(32'h8000 + 32'(4 * i), i);
            tick();
        end
        fetch_valid = 1'b0;
        chk("ar_pre_count", 64'(iq_count), 64'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(iq_valid), 64'd0);
        chk("ar_count", 64'(iq_count), 64'd0);
        chk("ar_fready", 64'(fetch_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_post_count", 64'(iq_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
